// File: rtl/conv3x3_channel_sched.sv
// conv3x3_channel_sched: per-channel 3x3 weight store and dot-unit sequencer that accumulates channel sums plus bias into one output pixel.
// Optional ReLU on the output register is enabled by defining CONV_RELU_EN.
module conv3x3_channel_sched #(
  parameter int SUM_WIDTH = 20,
  parameter int ACC_WIDTH = 24,
  parameter int CH_MAX    = 16,
  parameter int CH_W      = 5,
  parameter int CA_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CA_W-1:0]      cfg_addr,
  input  logic [7:0]           cfg_wdata,
  input  logic [CH_W-1:0]      num_ch,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [71:0]          s_data,
  output logic                 dot_in_vld,
  output logic [71:0]          dot_data,
  output logic [71:0]          dot_weight,
  input  logic [SUM_WIDTH-1:0] dot_ans,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 busy
);
  localparam int NW = CH_MAX * 9;
  typedef enum logic [1:0] {ACC, FIN, OUT} state_t;
  state_t                state_q, state_d;
  logic [7:0]            w_q [NW];
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d, nch_q, nch_d, nch_sel;
  logic [ACC_WIDTH-1:0]  bias_q, acc_q, acc_d, acc_sum, m_data_q, m_data_d, out_val;
  logic [CA_W-1:0]       wbase;
  logic                  pend_q, first_q, accept, first_acc, last_acc, cfg_ok;
  assign s_rdy      = state_q == ACC;
  assign accept     = s_vld & s_rdy;
  assign first_acc  = ch_cnt_q == '0;
  assign dot_in_vld = accept;
  assign dot_data   = s_data;
  assign m_vld      = state_q == OUT;
  assign m_data     = m_data_q;
  assign busy       = (state_q != ACC) | (ch_cnt_q != '0) | pend_q;
  assign cfg_ok     = cfg_we & ~busy & (32'(cfg_addr) < NW);
  assign nch_sel    = (num_ch == '0) ? CH_W'(1) : (32'(num_ch) > CH_MAX) ? CH_W'(CH_MAX) : num_ch;
  assign nch_d      = (accept & first_acc) ? nch_sel : nch_q;
  assign last_acc   = accept & (ch_cnt_q == nch_d - CH_W'(1));
  assign wbase      = CA_W'(32'(ch_cnt_q) * 9);
  // The first channel of a pixel restarts the sum from the latched bias.
  assign acc_sum    = (first_q ? bias_q : acc_q) + {{(ACC_WIDTH-SUM_WIDTH){dot_ans[SUM_WIDTH-1]}}, dot_ans};
  assign acc_d      = pend_q ? acc_sum : acc_q;
`ifdef CONV_RELU_EN
  assign out_val    = acc_d[ACC_WIDTH-1] ? '0 : acc_d;
`else
  assign out_val    = acc_d;
`endif
  for (genvar k = 0; k < 9; k++) begin : g_w
    assign dot_weight[8*k +: 8] = w_q[wbase + CA_W'(k)];
  end
  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    m_data_d = m_data_q;
    unique case (state_q)
      ACC: begin
        ch_cnt_d = accept ? (last_acc ? '0 : ch_cnt_q + CH_W'(1)) : ch_cnt_q;
        state_d  = last_acc ? FIN : ACC;
      end
      FIN: begin
        state_d  = OUT;
        m_data_d = out_val;
      end
      OUT:     state_d = m_rdy ? ACC : OUT;
      default: state_d = ACC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACC;
      ch_cnt_q <= '0;
      nch_q    <= CH_W'(1);
      bias_q   <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      pend_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      nch_q    <= nch_d;
      bias_q   <= (accept & first_acc) ? bias : bias_q;
      acc_q    <= acc_d;
      m_data_q <= m_data_d;
      pend_q   <= accept;
      first_q  <= accept & first_acc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (cfg_ok) begin
      w_q[cfg_addr] <= cfg_wdata;
    end
  end
endmodule

// File: doc/conv3x3_channel_sched.md
Name: conv3x3_channel_sched

Overview:
Sequencer for the team's 9-tap signed dot-product unit (8-bit data/weights, SUM_WIDTH sum, products registered on in_vld, sum valid one cycle after in_vld).
- Stores per-channel 3x3 weights and streams one 9-pixel window per channel into the dot unit.
- Accumulates the channel partial sums plus a bias, then emits one convolution output pixel over a valid/ready handshake.
- Sits between the window-fetch logic and the output writeback.

Parameters:
SUM_WIDTH, 20, width of the dot unit's ans.
ACC_WIDTH, 24, signed accumulator and output width.
CH_MAX, 16, maximum input channels per output pixel.
CH_W, 5, width of num_ch; equals clog2(CH_MAX+1).
CA_W, 8, width of cfg_addr; addresses CH_MAX*9 weight bytes.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_we  in  1  weight write strobe.
cfg_addr  in  CA_W  weight index = channel*9 + tap.
cfg_wdata  in  8  signed weight byte.
num_ch  in  CH_W  channels per pixel; sampled on first accept.
bias  in  ACC_WIDTH  signed bias; sampled on first accept.
s_vld  in  1  window valid.
s_rdy  out  1  window ready.
s_data  in  72  9 signed bytes; tap k at [8k+7:8k].
dot_in_vld  out  1  drives dot unit in_vld.
dot_data  out  72  drives dot unit data0..8 (tap k at [8k+7:8k]).
dot_weight  out  72  drives dot unit weight0..8 for the current channel.
dot_ans  in  SUM_WIDTH  dot unit ans.
m_vld  out  1  result valid.
m_rdy  in  1  result ready.
m_data  out  ACC_WIDTH  signed result.
busy  out  1  pixel in progress.

Behaviour:
- Asynchronous reset: state=ACC, ch_cnt=0, pend=0, acc=0, m_vld=0, m_data=0, all weights 0. Reset mid-pixel drops the partial result with no output.
- FSM:
  - ACC: s_rdy=1. An accept is s_vld&s_rdy.
    - dot_in_vld = accept (combinational).
    - dot_data = s_data (pass-through).
    - dot_weight = weight bank[ch_cnt].
    - ch_cnt increments on each accept.
    - On an accept with ch_cnt = nch-1: go to FIN and clear ch_cnt.
  - FIN: s_rdy=0. Performs the final add, then goes to OUT.
  - OUT: m_vld=1; m_data and acc held stable. On m_vld&m_rdy go to ACC; s_rdy is 1 in the following cycle.
- First accept (ch_cnt=0) latches nch from num_ch:
  - 0 becomes 1.
  - Values above CH_MAX become CH_MAX.
  - bias is latched at the same time.
- pend is set one cycle after every accept. While pend=1: acc <= (first channel ? bias : acc) + sign-extended dot_ans. pend can overlap the next accept; throughput is one channel per clock.
- Latency: final-channel accept at cycle t → m_vld high at t+2. A pixel takes nch+2 cycles minimum.
- Arithmetic: ACC_WIDTH two's complement, wraps on overflow. With defaults, 16 channels at -128*-128 fits.
- Config writes:
  - Accepted only when busy=0.
  - cfg_we while busy=1 is ignored.
  - cfg_addr >= CH_MAX*9 is ignored.
- busy = (state!=ACC) | (ch_cnt!=0) | pend.
- s_rdy=0 in FIN and OUT. Any s_vld there is held by the source and not consumed.

Optional Feature:
CONV_RELU_EN:
- Defined: m_data is 0 when acc is negative, otherwise acc. The ReLU is applied in the FIN-to-OUT register write.
- Undefined: m_data is raw acc.
- Timing and handshake are identical either way.

Test Plan:
- Ch0 weights all 1; num_ch=1; bias=0; s_data all 2 → m_vld 2 cycles after the accept, m_data=18, then s_rdy=1 after the handshake.
- Ch0/1/2 weights all 1/-1/2; num_ch=3; bias=5; three back-to-back windows all 10 → m_data=185. s_rdy=0 from the cycle after the 3rd accept until the m handshake.
- Backpressure: m_rdy=0 for 5 cycles in OUT → m_vld and m_data stay at 185, s_rdy=0, no further dot_in_vld. m_rdy=1 → single handshake, then s_rdy=1.
- num_ch=16; all weights -128; all data -128; bias=0 → m_data=2359296 after 18 cycles. cfg_we issued mid-pixel leaves the weights unchanged on the next pixel.
- num_ch=0; ch0 weights 1; data all 3 → processed as 1 channel, m_data=27. Asserting rst_n=0 during a 3-channel pixel → m_vld never rises and weights read back as 0.
- Ch0 weights -1; data all 10; bias=5; num_ch=1 → m_data=0 with CONV_RELU_EN defined, -85 without.
